modport_slave: RTL and testbench
================================

MODPORT_SLAVE -- requirements
Module: modport_slave

Interface
REQ-001 SHALL have parameter HADDR_SIZE, default 32, address bus width.
REQ-002 SHALL have parameter HDATA_SIZE, default 32, data bus width; only 32 is supported.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, number of 32-bit memory words; power of two.
REQ-004 SHALL have one clock, HCLK, and a reset port, HRESETn; the reset is asynchronous and active-high (asserted when HRESETn = 1).
REQ-005 SHALL have ports:
- HCLK  in  1  clock
- HRESETn  in  1  async reset, active-high
- HSEL  in  1  slave select
- HADDR  in  HADDR_SIZE  byte address
- HWRITE  in  1  1 = write, 0 = read
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word
- HBURST  in  3  burst type; ignored
- HPROT  in  4  protection; ignored
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HWDATA  in  HDATA_SIZE  write data, valid in data phase
- HREADY  in  1  bus ready
- HRDATA  out  HDATA_SIZE  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR

Function
REQ-006 SHALL accept a transfer at a rising HCLK edge when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ; it SHALL register HADDR, HWRITE and HSIZE as the pending data phase.
REQ-007 SHALL treat IDLE/BUSY, HSEL=0, or HREADY=0 as no transfer: no memory access; in the following cycle HREADYOUT=1 and HRESP=0.
REQ-008 SHALL index memory with word address HADDR[log2(MEM_DEPTH)+1:2]; upper address bits are handled per REQ-017/018.
REQ-009 Write data phase: zero wait states; HREADYOUT=1, HRESP=0; at the edge ending the data phase, the HWDATA byte lanes selected by HSIZE and HADDR[1:0] SHALL be written; other bytes are unchanged.
REQ-010 Byte lanes SHALL be little-endian: byte n = HWDATA[8n+7:8n]; halfword at HADDR[1]=0 uses bytes 0-1 and at HADDR[1]=1 uses bytes 2-3; a word uses all four bytes.
REQ-011 Read data phase: zero wait states; HRDATA SHALL be the full 32-bit addressed word, driven combinationally from the registered address during the data phase; the master extracts the lanes.
REQ-012 Outside a read data phase, HRDATA SHALL be 0.
REQ-013 A read whose address phase overlaps a write's data phase to the same word SHALL return the newly written data.
REQ-014 Back-to-back transfers (NONSEQ/SEQ in consecutive cycles) SHALL be sustained at one transfer per cycle.
REQ-015 HBURST and HPROT SHALL have no effect.

Reset
REQ-016 While HRESETn=1: HREADYOUT=1, HRESP=0, HRDATA=0, the pending data phase SHALL be cleared, and all memory words SHALL be cleared to 0; an in-flight write SHALL be dropped.

Configuration
REQ-017 With ERROR_RESP_EN defined: an accepted transfer with out-of-range address (HADDR >= 4*MEM_DEPTH), HSIZE > 2, or misalignment (halfword with HADDR[0]=1; word with HADDR[1:0]!=0) SHALL get a two-cycle ERROR: cycle 1 HREADYOUT=0, HRESP=1; cycle 2 HREADYOUT=1, HRESP=1; no memory write; HRDATA=0. A transfer presented during cycle 1 SHALL be ignored.
REQ-018 Without ERROR_RESP_EN: HRESP SHALL always be 0 and HREADYOUT SHALL always be 1; addresses wrap modulo 4*MEM_DEPTH; misaligned low bits SHALL be ignored (aligned down); HSIZE > 2 SHALL be treated as a word.

Verification
REQ-019 Reset, then word write 0xDEADBEEF to 0x10, then word read of 0x10 -> HRDATA=0xDEADBEEF, HRESP=0, HREADYOUT=1 throughout.
REQ-020 Word write 0x00000000 to 0x20, then byte write 0xAB to 0x22 -> word read of 0x20 returns 0x00AB0000.
REQ-021 Halfword write 0x1234 to 0x32 after word write 0xFFFFFFFF to 0x30 -> read of 0x30 returns 0x1234FFFF.
REQ-022 Back-to-back word writes 0x11111111 to 0x40 and 0x22222222 to 0x44, then reads of 0x40 and 0x44 -> 0x11111111, 0x22222222 with no wait states; a read issued in the cycle right after the 0x44 write returns 0x22222222.
REQ-023 HTRANS=IDLE with HSEL=1 and HWRITE=1 to 0x50 holding 0x5A5A5A5A -> memory unchanged, HRESP=0.
REQ-024 With ERROR_RESP_EN: word write to 0x402 (MEM_DEPTH=256) -> HREADYOUT 0 then 1, HRESP 1 for both cycles, no write; without the macro, word 0x400 wraps to word 0x000.

Source files
------------

// File: rtl/modport_slave.sv
// modport_slave: zero-wait-state AHB-Lite style memory slave with byte-lane writes.
// Memory is MEM_DEPTH x 32-bit words, cleared by reset.
// Optional feature macro: ERROR_RESP_EN. When it is defined, out-of-range,
// oversize or misaligned transfers get a two-cycle ERROR response. When it is
// undefined, addresses wrap, misaligned low bits are aligned down, and HSIZE > 2
// is treated as a word.
// Note: HRESETn is active-HIGH despite its name.

module modport_slave #(
    parameter int unsigned HADDR_SIZE = 32,
    parameter int unsigned HDATA_SIZE = 32,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int unsigned AW     = $clog2(MEM_DEPTH);
    localparam int unsigned NLANES = 4;

    // Byte-lane enables for one transfer, little-endian lanes.
    function automatic logic [NLANES-1:0] lane_strobe(input logic [2:0] size,
                                                      input logic [1:0] lo);
        logic [NLANES-1:0] strb;
        case (size)
            3'd0:    strb = 4'b0001 << lo;
            3'd1:    strb = lo[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    logic take_c;
    logic accept_c;

    // Pending data phase.
    logic              dp_valid_q, dp_valid_d;
    logic              dp_write_q, dp_write_d;
    logic [AW-1:0]     dp_idx_q,   dp_idx_d;
    logic [NLANES-1:0] dp_strb_q,  dp_strb_d;

    logic [HDATA_SIZE-1:0] mem_q [MEM_DEPTH];

    // A bus cycle carries a real transfer only when selected, ready and NONSEQ/SEQ.
    assign take_c = HSEL & HREADY & HTRANS[1];

`ifdef ERROR_RESP_EN
    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } err_state_e;

    err_state_e state_q;
    logic       hreadyout_q;
    logic       hresp_q;
    logic       addr_bad_c;
    logic       size_bad_c;
    logic       align_bad_c;
    logic       bad_c;

    // Classify the address phase; anything outside the array or misaligned is refused.
    assign addr_bad_c  = (HADDR >> (AW + 2)) != '0;
    assign size_bad_c  = HSIZE > 3'd2;
    assign align_bad_c = ((HSIZE == 3'd1) && HADDR[0]) ||
                         ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    assign bad_c       = addr_bad_c | size_bad_c | align_bad_c;

    // Transfers offered during the first error cycle are dropped.
    assign accept_c = take_c & ~bad_c & (state_q != ST_ERR1);

    // Two-cycle ERROR response sequencer with registered HREADYOUT/HRESP.
    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            state_q     <= ST_OK;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_ERR1: begin
                    state_q     <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                end
                default: begin
                    if (take_c && bad_c) begin
                        state_q     <= ST_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= 1'b1;
                    end else begin
                        state_q     <= ST_OK;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
`else
    // Every offered transfer is accepted; the word index simply wraps.
    assign accept_c  = take_c;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
`endif

    // Capture the address phase into the next data phase.
    always_comb begin
        dp_valid_d = accept_c;
        dp_write_d = HWRITE;
        dp_idx_d   = HADDR[AW+1:2];
        dp_strb_d  = lane_strobe(HSIZE, HADDR[1:0]);
    end

    // Data-phase register; cleared by reset so an in-flight write is dropped.
    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_idx_q   <= '0;
            dp_strb_q  <= '0;
        end else begin
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_idx_q   <= dp_idx_d;
            dp_strb_q  <= dp_strb_d;
        end
    end

    // Memory array: cleared by reset, byte-lane write at the edge ending a write data phase.
    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (dp_valid_q && dp_write_q) begin
            for (int unsigned b = 0; b < NLANES; b++) begin
                if (dp_strb_q[b]) begin
                    mem_q[dp_idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Full addressed word during a read data phase, zero otherwise.
    assign HRDATA = (dp_valid_q && !dp_write_q) ? mem_q[dp_idx_q] : '0;

    // Burst type and protection carry no meaning for this slave.
    logic unused_c;
    assign unused_c = ^{HBURST, HPROT, HADDR};

endmodule

// File: tb/tb_modport_slave.sv
// Self-checking bench for modport_slave against a byte-addressed reference memory.
`timescale 1ns/1ps

module tb_modport_slave;

    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned SPAN      = 4 * MEM_DEPTH;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    int checks = 0;
    int errors = 0;

    // Reference memory as individual bytes.
    logic [7:0] model_mem [SPAN];

    // Bench-side view of the transfer whose data phase is in progress.
    logic        pend_valid = 1'b0;
    logic        pend_write = 1'b0;
    logic [31:0] pend_addr  = '0;
    logic [2:0]  pend_size  = '0;
    logic [31:0] pend_wdata = '0;

    modport_slave #(
        .HADDR_SIZE(32),
        .HDATA_SIZE(32),
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HSEL     (HSEL),
        .HADDR    (HADDR),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HBURST   (HBURST),
        .HPROT    (HPROT),
        .HTRANS   (HTRANS),
        .HWDATA   (HWDATA),
        .HREADY   (HREADY),
        .HRDATA   (HRDATA),
        .HREADYOUT(HREADYOUT),
        .HRESP    (HRESP)
    );

    always #5 HCLK = ~HCLK;

    function automatic bit is_bad(input logic [31:0] a, input logic [2:0] sz);
        return (a >= SPAN) || (sz > 3'd2) || ((sz == 3'd1) && a[0]) ||
               ((sz == 3'd2) && (a[1:0] != 2'b00));
    endfunction

    // Byte-wise write: pick the bytes covered by the transfer, take each from its lane.
    function automatic void model_write(input logic [31:0] addr, input logic [2:0] sz,
                                        input logic [31:0] wd);
        int unsigned a;
        int unsigned base;
        int unsigned n;
        int unsigned lane;
        a = addr % SPAN;
        if (sz == 3'd0) begin
            base = a; n = 1;
        end else if (sz == 3'd1) begin
            base = (a / 4) * 4 + ((a / 2) % 2) * 2; n = 2;
        end else begin
            base = (a / 4) * 4; n = 4;
        end
        for (int unsigned k = 0; k < n; k++) begin
            lane = (base + k) % 4;
            model_mem[base + k] = wd[8*lane +: 8];
        end
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        int unsigned base;
        base = ((addr % SPAN) / 4) * 4;
        return {model_mem[base + 3], model_mem[base + 2], model_mem[base + 1], model_mem[base]};
    endfunction

    function automatic void model_clear();
        for (int unsigned i = 0; i < SPAN; i++) model_mem[i] = 8'h00;
    endfunction

    // One bus cycle: sample the current data phase, then drive the next address phase.
    task automatic bus_step(input logic sel, input logic rdy_in, input logic [1:0] trans,
                            input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                            input logic [31:0] wd,
                            output logic [31:0] rd, output logic rdy, output logic rsp,
                            output logic [31:0] exp_rd);
        @(negedge HCLK);
        rd  = HRDATA;
        rdy = HREADYOUT;
        rsp = HRESP;
        exp_rd = (pend_valid && !pend_write) ? model_word(pend_addr) : 32'h0;
        if (pend_valid && pend_write) model_write(pend_addr, pend_size, pend_wdata);
        HWDATA = (pend_valid && pend_write) ? pend_wdata : $urandom();
        HSEL   = sel;
        HREADY = rdy_in;
        HTRANS = trans;
        HWRITE = wr;
        HSIZE  = sz;
        HADDR  = addr;
        HBURST = 3'($urandom());
        HPROT  = 4'($urandom());
        pend_valid = sel && rdy_in && trans[1];
`ifdef ERROR_RESP_EN
        if (is_bad(addr, sz)) pend_valid = 1'b0;
`endif
        pend_write = wr;
        pend_addr  = addr;
        pend_size  = sz;
        pend_wdata = wd;
    endtask

    task automatic test_reset();
        HRESETn = 1'b1; HSEL = 0; HADDR = '0; HWRITE = 0; HSIZE = '0; HBURST = '0;
        HPROT = '0; HTRANS = 2'd0; HWDATA = '0; HREADY = 1'b1;
        model_clear();
        repeat (2) @(negedge HCLK);
        checks++;
        if ({HREADYOUT, HRESP} !== 2'b10) begin
            errors++; $display("FAIL reset_resp: got rdy=%b resp=%b want rdy=1 resp=0", HREADYOUT, HRESP);
        end
        checks++;
        if (HRDATA !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h want 00000000", HRDATA);
        end
        HRESETn = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] rd, e; logic rdy, rsp;
        bus_step(1, 1, 2'd2, 1, 3'd2, 32'h10, 32'hDEADBEEF, rd, rdy, rsp, e);
        bus_step(1, 1, 2'd2, 0, 3'd2, 32'h10, 32'h0, rd, rdy, rsp, e);
        checks++;
        if ({rdy, rsp} !== 2'b10 || rd !== 32'h0) begin
            errors++; $display("FAIL basic_write_phase: got rdy=%b resp=%b rd=%h want 1 0 00000000", rdy, rsp, rd);
        end
        bus_step(1, 1, 2'd0, 0, 3'd0, 32'h0, 32'h0, rd, rdy, rsp, e);
        checks++;
        if ({rdy, rsp} !== 2'b10 || rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL basic_read: got rdy=%b resp=%b rd=%h want 1 0 deadbeef", rdy, rsp, rd);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd, e; logic rdy, rsp;
        bus_step(1, 1, 2'd2, 1, 3'd2, 32'h20, 32'h0, rd, rdy, rsp, e);
        bus_step(1, 1, 2'd3, 1, 3'd0, 32'h22, {8'($urandom()), 8'hAB, 16'($urandom())}, rd, rdy, rsp, e);
        bus_step(1, 1, 2'd2, 0, 3'd2, 32'h20, 32'h0, rd, rdy, rsp, e);
        bus_step(1, 1, 2'd0, 0, 3'd0, 32'h0, 32'h0, rd, rdy, rsp, e);
        checks++;
        if (rd !== 32'h00AB0000) begin
            errors++; $display("FAIL byte_write: got %h want 00ab0000", rd);
        end
        bus_step(1, 1, 2'd2, 1, 3'd2, 32'h30, 32'hFFFFFFFF, rd, rdy, rsp, e);
        bus_step(1, 1, 2'd2, 1, 3'd1, 32'h32, {16'h1234, 16'($urandom())}, rd, rdy, rsp, e);
        bus_step(1, 1, 2'd2, 0, 3'd2, 32'h30, 32'h0, rd, rdy, rsp, e);
        bus_step(1, 1, 2'd0, 0, 3'd0, 32'h0, 32'h0, rd, rdy, rsp, e);
        checks++;
        if (rd !== 32'h1234FFFF) begin
            errors++; $display("FAIL half_write: got %h want 1234ffff", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, e; logic rdy, rsp;
        logic [31:0] want [4] = '{32'h0, 32'h22222222, 32'h11111111, 32'h22222222};
        bus_step(1, 1, 2'd2, 1, 3'd2, 32'h40, 32'h11111111, rd, rdy, rsp, e);
        bus_step(1, 1, 2'd3, 1, 3'd2, 32'h44, 32'h22222222, rd, rdy, rsp, e);
        bus_step(1, 1, 2'd2, 0, 3'd2, 32'h44, 32'h0, rd, rdy, rsp, e);
        checks++;
        if ({rdy, rsp} !== 2'b10) begin
            errors++; $display("FAIL b2b_write_ready: got rdy=%b resp=%b want 1 0", rdy, rsp);
        end
        bus_step(1, 1, 2'd3, 0, 3'd2, 32'h40, 32'h0, rd, rdy, rsp, e);
        checks++;
        if (rd !== want[1] || {rdy, rsp} !== 2'b10) begin
            errors++; $display("FAIL b2b_read_after_write: got %h rdy=%b want %h rdy=1", rd, rdy, want[1]);
        end
        bus_step(1, 1, 2'd3, 0, 3'd2, 32'h44, 32'h0, rd, rdy, rsp, e);
        checks++;
        if (rd !== want[2] || {rdy, rsp} !== 2'b10) begin
            errors++; $display("FAIL b2b_read_40: got %h rdy=%b want %h rdy=1", rd, rdy, want[2]);
        end
        bus_step(1, 1, 2'd0, 0, 3'd0, 32'h0, 32'h0, rd, rdy, rsp, e);
        checks++;
        if (rd !== want[3] || {rdy, rsp} !== 2'b10) begin
            errors++; $display("FAIL b2b_read_44: got %h rdy=%b want %h rdy=1", rd, rdy, want[3]);
        end
    endtask

    task automatic test_idle();
        logic [31:0] rd, e; logic rdy, rsp;
        bus_step(1, 1, 2'd2, 1, 3'd2, 32'h50, 32'h5A5A5A5A, rd, rdy, rsp, e);
        bus_step(1, 1, 2'd0, 1, 3'd2, 32'h50, 32'hFFFFFFFF, rd, rdy, rsp, e);
        bus_step(1, 1, 2'd1, 1, 3'd2, 32'h50, 32'h00000000, rd, rdy, rsp, e);
        bus_step(0, 1, 2'd2, 1, 3'd2, 32'h50, 32'h12345678, rd, rdy, rsp, e);
        checks++;
        if ({rdy, rsp} !== 2'b10 || rd !== 32'h0) begin
            errors++; $display("FAIL idle_resp: got rdy=%b resp=%b rd=%h want 1 0 00000000", rdy, rsp, rd);
        end
        bus_step(1, 0, 2'd2, 1, 3'd2, 32'h50, 32'h87654321, rd, rdy, rsp, e);
        bus_step(1, 1, 2'd2, 0, 3'd2, 32'h50, 32'h0, rd, rdy, rsp, e);
        checks++;
        if ({rdy, rsp} !== 2'b10 || rd !== 32'h0) begin
            errors++; $display("FAIL nosel_resp: got rdy=%b resp=%b rd=%h want 1 0 00000000", rdy, rsp, rd);
        end
        bus_step(1, 1, 2'd0, 0, 3'd0, 32'h0, 32'h0, rd, rdy, rsp, e);
        checks++;
        if (rd !== 32'h5A5A5A5A) begin
            errors++; $display("FAIL idle_no_write: got %h want 5a5a5a5a", rd);
        end
    endtask

`ifdef ERROR_RESP_EN
    task automatic test_error();
        logic [31:0] rd, e; logic rdy, rsp;
        bus_step(1, 1, 2'd2, 1, 3'd2, 32'h0, 32'h13579BDF, rd, rdy, rsp, e);
        bus_step(1, 1, 2'd2, 1, 3'd2, 32'h402, 32'hFFFFFFFF, rd, rdy, rsp, e);
        bus_step(1, 1, 2'd2, 1, 3'd2, 32'h0, 32'hEEEEEEEE, rd, rdy, rsp, e);
        pend_valid = 1'b0;
        checks++;
        if ({rdy, rsp} !== 2'b01 || rd !== 32'h0) begin
            errors++; $display("FAIL err_cycle1: got rdy=%b resp=%b rd=%h want 0 1 00000000", rdy, rsp, rd);
        end
        bus_step(1, 1, 2'd0, 0, 3'd0, 32'h0, 32'h0, rd, rdy, rsp, e);
        checks++;
        if ({rdy, rsp} !== 2'b11 || rd !== 32'h0) begin
            errors++; $display("FAIL err_cycle2: got rdy=%b resp=%b rd=%h want 1 1 00000000", rdy, rsp, rd);
        end
        bus_step(1, 1, 2'd2, 0, 3'd2, 32'h0, 32'h0, rd, rdy, rsp, e);
        checks++;
        if ({rdy, rsp} !== 2'b10) begin
            errors++; $display("FAIL err_recover: got rdy=%b resp=%b want 1 0", rdy, rsp);
        end
        bus_step(1, 1, 2'd0, 0, 3'd0, 32'h0, 32'h0, rd, rdy, rsp, e);
        checks++;
        if (rd !== 32'h13579BDF) begin
            errors++; $display("FAIL err_no_write: got %h want 13579bdf", rd);
        end
    endtask
`else
    task automatic test_wrap();
        logic [31:0] rd, e; logic rdy, rsp;
        bus_step(1, 1, 2'd2, 1, 3'd2, 32'h400, 32'hCAFEF00D, rd, rdy, rsp, e);
        bus_step(1, 1, 2'd2, 1, 3'd2, 32'h7, 32'h0BADF00D, rd, rdy, rsp, e);
        bus_step(1, 1, 2'd2, 0, 3'd2, 32'h0, 32'h0, rd, rdy, rsp, e);
        bus_step(1, 1, 2'd2, 0, 3'd2, 32'h4, 32'h0, rd, rdy, rsp, e);
        checks++;
        if (rd !== 32'hCAFEF00D || {rdy, rsp} !== 2'b10) begin
            errors++; $display("FAIL wrap_400: got %h rdy=%b resp=%b want cafef00d 1 0", rd, rdy, rsp);
        end
        bus_step(1, 1, 2'd0, 0, 3'd0, 32'h0, 32'h0, rd, rdy, rsp, e);
        checks++;
        if (rd !== 32'h0BADF00D) begin
            errors++; $display("FAIL misaligned_word: got %h want 0badf00d", rd);
        end
    endtask
`endif

    task automatic test_reset_midwrite();
        logic [31:0] rd, e; logic rdy, rsp;
        bus_step(1, 1, 2'd2, 1, 3'd2, 32'h60, 32'h600DF00D, rd, rdy, rsp, e);
        @(negedge HCLK);
        HWDATA = 32'h600DF00D; HSEL = 1'b0; HTRANS = 2'd0;
        HRESETn = 1'b1;
        #1;
        checks++;
        if ({HREADYOUT, HRESP} !== 2'b10 || HRDATA !== 32'h0) begin
            errors++; $display("FAIL reset_async: got rdy=%b resp=%b rd=%h want 1 0 00000000", HREADYOUT, HRESP, HRDATA);
        end
        pend_valid = 1'b0;
        model_clear();
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b0;
        bus_step(1, 1, 2'd2, 0, 3'd2, 32'h60, 32'h0, rd, rdy, rsp, e);
        bus_step(1, 1, 2'd2, 0, 3'd2, 32'h10, 32'h0, rd, rdy, rsp, e);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL reset_drop_write: got %h want 00000000", rd);
        end
        bus_step(1, 1, 2'd0, 0, 3'd0, 32'h0, 32'h0, rd, rdy, rsp, e);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL reset_clear_mem: got %h want 00000000", rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, e, addr; logic rdy, rsp, sel, rin, wr;
        logic [1:0] tr; logic [2:0] sz;
        for (int n = 0; n <= 300; n++) begin
            sel = $urandom_range(0, 7) != 0;
            rin = $urandom_range(0, 7) != 0;
            tr  = 2'($urandom());
            wr  = 1'($urandom());
`ifdef ERROR_RESP_EN
            sz   = 3'($urandom_range(0, 2));
            addr = 32'($urandom_range(0, 63));
            if (sz == 3'd1) addr[0] = 1'b0;
            if (sz == 3'd2) addr[1:0] = 2'b00;
`else
            sz   = 3'($urandom_range(0, 3));
            addr = 32'($urandom_range(0, 63)) + (($urandom_range(0, 3) == 0) ? SPAN : 0);
`endif
            if (n == 300) begin
                sel = 1'b0; tr = 2'd0;
            end
            bus_step(sel, rin, tr, wr, sz, addr, $urandom(), rd, rdy, rsp, e);
            checks++;
            if (rd !== e) begin
                errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", n, rd, e);
            end
            checks++;
            if ({rdy, rsp} !== 2'b10) begin
                errors++; $display("FAIL rand_resp[%0d]: got rdy=%b resp=%b want 1 0", n, rdy, rsp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_lanes();
        test_back_to_back();
        test_idle();
`ifdef ERROR_RESP_EN
        test_error();
`else
        test_wrap();
`endif
        test_reset_midwrite();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
